// File: rtl/dmem_arbiter.sv
//==============================================================================
// Module      : dmem_arbiter
// Description : Shares a single-port word memory between the CPU MEM stage and
//               a DMA/debug port, with a starvation bound and a response register.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int DEPTH    = 100,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_ad_i,
    input  logic [31:0] cpu_wd_i,
    output logic [31:0] cpu_rd_o,
    output logic        cpu_stall_o,
    input  logic        dma_req_valid_i,
    output logic        dma_req_ready_o,
    input  logic        dma_we_i,
    input  logic [31:0] dma_ad_i,
    input  logic [31:0] dma_wd_i,
    output logic        dma_rsp_valid_o,
    input  logic        dma_rsp_ready_i,
    output logic [31:0] dma_rsp_data_o,
    output logic        dma_rsp_err_o,
    output logic        mem_we_o,
    output logic [31:0] mem_ad_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i
);

    localparam int             CW        = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0]  WAIT_MAX  = CW'(MAX_WAIT);
    localparam logic [31:0]    DEPTH_LIM = 32'(DEPTH);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;

    logic cpu_in_range;
    logic dma_in_range;
    logic rsp_free;
    logic dma_go;

    assign cpu_in_range = (cpu_ad_i < DEPTH_LIM);
    assign dma_in_range = (dma_ad_i < DEPTH_LIM);
    assign rsp_free     = (state_q == S_EMPTY) || dma_rsp_ready_i;
    assign dma_go       = dma_req_valid_i && rsp_free &&
                          (!cpu_req_i || (wait_cnt_q == WAIT_MAX));

    // Memory port steering; writes are suppressed for out-of-range indices and in reset.
    always_comb begin
        mem_ad_o        = cpu_ad_i;
        mem_wd_o        = cpu_wd_i;
        mem_we_o        = cpu_req_i && cpu_we_i && cpu_in_range;
        dma_req_ready_o = 1'b0;
        cpu_stall_o     = 1'b0;
        if (dma_go) begin
            mem_ad_o        = dma_ad_i;
            mem_wd_o        = dma_wd_i;
            mem_we_o        = dma_we_i && dma_in_range;
            dma_req_ready_o = 1'b1;
            cpu_stall_o     = cpu_req_i;
        end
        if (!rst_n) begin
            mem_we_o = 1'b0;
        end
    end

    assign cpu_rd_o = cpu_in_range ? mem_rd_i : 32'd0;

    // A full response register stalls the DMA side and must not count as starvation.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!dma_req_valid_i || dma_go) begin
            wait_cnt_d = '0;
        end else if (rsp_free && (wait_cnt_q != WAIT_MAX)) begin
            wait_cnt_d = wait_cnt_q + CW'(1);
        end
    end

    always_comb begin
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        if (dma_go) begin
            rsp_data_d = (dma_we_i || !dma_in_range) ? 32'd0 : mem_rd_i;
            rsp_err_d  = !dma_in_range;
        end
    end

    // Response FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Response FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (dma_go)               state_d = S_FULL;
            S_FULL:  if (!dma_go && dma_rsp_ready_i) state_d = S_EMPTY;
            default:                           state_d = S_EMPTY;
        endcase
    end

    // Response FSM: outputs
    always_comb begin
        dma_rsp_valid_o = (state_q == S_FULL);
        dma_rsp_data_o  = rsp_data_q;
        dma_rsp_err_o   = rsp_err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            rsp_data_q <= 32'd0;
            rsp_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

endmodule

`default_nettype wire
